// File: rtl/step_ctrl.sv
// Debounced run/single-step clock enable for the datapath, with step counter.
// Optional hold-to-repeat stepping is built when STEP_AUTOREPEAT_EN is defined.
module step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_step_n,
  input  logic        sw_single,
  output logic        clk_en,
  output logic        single_mode,
  output logic [15:0] step_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 ||
      REPEAT_PERIOD < 2) begin : g_cfg_chk
    $error("step_ctrl: timing parameters must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PULSE    = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t state;
  state_t state_n;

  logic          key_s1;
  logic          key_sync;
  logic          sw_s1;
  logic          sw_sync;
  logic          key_deb;
  logic          key_deb_q;
  logic [DW-1:0] deb_cnt;
  logic [15:0]   step_cnt;
  logic          press;
  logic          hold_hit;

  // Released key and free-run switch are the safe power-up levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1   <= 1'b1;
      key_sync <= 1'b1;
      sw_s1    <= 1'b0;
      sw_sync  <= 1'b0;
    end else begin
      key_s1   <= key_step_n;
      key_sync <= key_s1;
      sw_s1    <= sw_single;
      sw_sync  <= sw_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_deb   <= 1'b1;
      key_deb_q <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      key_deb_q <= key_deb;
      if (key_sync == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_deb <= key_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Edge only: a key already down on entry to IDLE cannot step.
  assign press = key_deb_q & ~key_deb;

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt;
  logic          repeating;

  // hold_cnt equals the number of cycles since the last PULSE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (state_n == PULSE) begin
      hold_cnt  <= '0;
      repeating <= (state == WAIT_REL);
    end else if (state == PULSE || state == WAIT_REL) begin
      hold_cnt  <= hold_cnt + HW'(1);
    end
  end

  assign hold_hit = repeating ? (hold_cnt == PER_LAST)
                              : (hold_cnt == DLY_LAST);
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!sw_sync)   state_n = RUN;
        else if (press) state_n = PULSE;
      end
      RUN: begin
        if (sw_sync) state_n = IDLE;
      end
      PULSE: begin
        state_n = WAIT_REL;
      end
      WAIT_REL: begin
        if (key_deb)       state_n = sw_sync ? IDLE : RUN;
        else if (hold_hit) state_n = PULSE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clk_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state  <= state_n;
      clk_en <= (state_n == RUN) || (state_n == PULSE);
      if (state_n == PULSE) step_cnt <= step_cnt + 16'd1;
    end
  end

  assign single_mode = (state != RUN);
  assign step_count  = step_cnt;

endmodule

// File: tb/tb_step_ctrl.sv
// Randomized and directed bench for step_ctrl against a history-based model.
// Define STEP_AUTOREPEAT_EN for both files to exercise hold-to-repeat.
module tb_step_ctrl;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
`ifdef STEP_AUTOREPEAT_EN
  localparam int EXP_HELD30 = 3;
`else
  localparam int EXP_HELD30 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key = 1'b1;
  logic        sw  = 1'b0;
  logic        clk_en;
  logic        single_mode;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_step_n(key),
    .sw_single(sw),
    .clk_en(clk_en),
    .single_mode(single_mode),
    .step_count(step_count)
  );

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int en_log[$];

  // Model: pin pipelines, debounced key, and mode flags.
  bit mk1, mk2, ms1, ms2, md, mdp;
  bit m_run, m_pulse, m_wait, m_en, m_rep;
  logic [15:0] m_cnt;
  int m_since;
  bit hist[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    mk1 = 1; mk2 = 1; ms1 = 0; ms2 = 0; md = 1; mdp = 1;
    m_run = 0; m_pulse = 0; m_wait = 0; m_en = 0; m_rep = 0;
    m_cnt = 16'h0; m_since = 0;
    hist.delete();
    for (int i = 0; i < DEB; i++) hist.push_back(1'b1);
  endtask

  task automatic m_next(bit k, bit s);
    bit press, flip, nrun, npulse, nwait;
    press = mdp && !md;
    hist.push_back(mk2);
    if (hist.size() > DEB) void'(hist.pop_front());
    // key_deb follows once DEB consecutive synced samples disagree
    flip = 1;
    foreach (hist[i]) if (hist[i] == md) flip = 0;
    nrun = 0; npulse = 0; nwait = 0;
    if (m_pulse) nwait = 1;
    else if (m_run) nrun = !ms2;
    else if (m_wait) begin
      if (md) nrun = !ms2;
      else begin
`ifdef STEP_AUTOREPEAT_EN
        if (m_since + 1 == (m_rep ? RPER : RDLY)) npulse = 1;
        else nwait = 1;
`else
        nwait = 1;
`endif
      end
    end else begin
      if (!ms2) nrun = 1;
      else if (press) npulse = 1;
    end
    if (npulse) begin
      m_rep = m_wait;
      m_since = 0;
      m_cnt = m_cnt + 16'd1;
    end else m_since++;
    mdp = md;
    if (flip) md = !md;
    ms2 = ms1; ms1 = s; mk2 = mk1; mk1 = k;
    m_run = nrun; m_pulse = npulse; m_wait = nwait;
    m_en = nrun | npulse;
  endtask

  task automatic tick(bit k, bit s);
    key = k;
    sw = s;
    m_next(k, s);
    @(posedge clk);
    #1;
    cyc++;
    chk("clk_en", clk_en, m_en);
    chk("single_mode", single_mode, !m_run);
    chk("step_count", step_count, m_cnt);
    if (clk_en) en_log.push_back(cyc);
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    #1;
    m_reset();
    chk("rst_clk_en", clk_en, 0);
    chk("rst_single", single_mode, 1);
    chk("rst_count", step_count, 0);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_hold_en", clk_en, 0);
    end
    rst = 1'b1;
  endtask

  task automatic idle_n(int n, bit s);
    repeat (n) tick(1'b1, s);
  endtask

  initial begin
    int t, r, c0, run_len;
    bit kr, sr;

    // reset, free-run
    @(posedge clk);
    #1;
    do_reset(3);
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      if (i >= 3) chk("run_after_rst", clk_en, 1);
    end

    // clean press in step mode
    idle_n(6, 1'b1);
    en_log.delete();
    t = cyc;
    repeat (30) tick(1'b0, 1'b1);
    idle_n(12, 1'b1);
    chk("clean_pulses", en_log.size(), EXP_HELD30);
    chk("clean_at", en_log.size() > 0 ? en_log[0] : -1, t + 7);

    // bounce then stable low
    en_log.delete();
    c0 = step_count;
    for (int i = 0; i < 40; i++) tick(((i / 3) % 2) != 0, 1'b1);
    t = cyc;
    repeat (20) tick(1'b0, 1'b1);
    idle_n(12, 1'b1);
    chk("bounce_pulses", en_log.size(), 1);
    chk("bounce_at", en_log.size() > 0 ? en_log[0] : -1, t + 7);
    chk("bounce_count", step_count, c0 + 1);

    // counter wrap
    force dut.step_cnt = 16'hFFFF;
    #1;
    release dut.step_cnt;
    m_cnt = 16'hFFFF;
    repeat (12) tick(1'b0, 1'b1);
    idle_n(12, 1'b1);
    chk("wrap", step_count, 16'h0000);

    // switch to run while key held
    repeat (10) tick(1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0);
    r = cyc;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b0);
      if (i <= 6) chk("held_off", clk_en, 0);
      else chk("held_on", clk_en, 1);
    end

    // switch to step while key held in run: no step
    c0 = step_count;
    repeat (10) tick(1'b0, 1'b0);
    repeat (15) tick(1'b0, 1'b1);
    idle_n(15, 1'b1);
    chk("flip_no_step", step_count, c0);

`ifdef STEP_AUTOREPEAT_EN
    en_log.delete();
    t = cyc;
    repeat (50) tick(1'b0, 1'b1);
    idle_n(20, 1'b1);
    chk("rep_pulses", en_log.size(), 5);
    foreach (en_log[i]) begin
      case (i)
        0: chk("rep_at0", en_log[i], t + 7);
        1: chk("rep_at1", en_log[i], t + 27);
        2: chk("rep_at2", en_log[i], t + 35);
        3: chk("rep_at3", en_log[i], t + 43);
        default: chk("rep_at4", en_log[i], t + 51);
      endcase
    end
`endif

    // random key bounce and mode changes, with a mid-run reset
    kr = 1'b1;
    sr = 1'b1;
    run_len = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(2);
      if (run_len == 0) begin
        kr = ~kr;
        run_len = $urandom_range(1, 12);
      end
      run_len--;
      if ($urandom_range(0, 99) == 0) sr = ~sr;
      tick(kr, sr);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Debounced run/single-step controller for the board's datapath clock. It sits directly upstream of the top-level chip interface. It turns the raw step push-button and the run/step slide switch into a glitch-free, single-cycle clock enable (`clk_en`) for the datapath, so the datapath runs on the 50 MHz board clock in both modes. It also exposes a step counter that the hex display mux can show next to the register values.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key change (10 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25000000: hold time before auto-repeat starts (only with `STEP_AUTOREPEAT_EN`).
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat steps (only with `STEP_AUTOREPEAT_EN`).

Ports:
- `clk` input 1: 50 MHz board clock; the only clock.
- `rst` input 1: asynchronous, active-low reset.
- `key_step_n` input 1: raw push-button, 0 = pressed; asynchronous to `clk`.
- `sw_single` input 1: raw slide switch, 1 = single-step mode, 0 = free run; asynchronous.
- `clk_en` output 1: datapath advances on every `clk` edge where this is 1; registered.
- `single_mode` output 1: 1 when the FSM is in any step-mode state.
- `step_count` output 16: number of single steps issued; wraps from 0xFFFF to 0x0000.

## Operation
- Inputs:
  - Each input passes through its own 2-flop synchronizer.
  - Reset values: key flops reset to 1 (released); switch flops reset to 0.
- Debounce (key only):
  - `key_deb` resets to 1.
  - A counter increments each cycle that the synchronized key differs from `key_deb`. It clears on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the values still differing, `key_deb` takes the new value and the counter clears.
- Press event: the cycle in which `key_deb` goes from 1 to 0. A key already held when entering step mode never produces an event.
- FSM states and transitions:
  - IDLE (reset state): `sw_sync=0` -> RUN; otherwise a press event -> PULSE.
  - RUN: `sw_sync=1` -> IDLE.
  - PULSE: lasts exactly one cycle, then -> WAIT_REL unconditionally. `step_count` increments on entry.
  - WAIT_REL: `key_deb=1` -> IDLE if `sw_sync=1`, or RUN if `sw_sync=0`.
- `clk_en` is 1 exactly when the registered state is RUN or PULSE.
- `single_mode` is 1 in IDLE, PULSE and WAIT_REL.
- Reset values: `clk_en=0`, `single_mode=1`, `step_count=0`, all counters 0.
- Boundary cases:
  - Switch change during PULSE or WAIT_REL: takes effect only after the key is released.
  - Switch flipped while the key is held: no step is issued.
  - Reset asserted mid-operation: the state is forced to IDLE immediately (asynchronous) and any in-progress debounce count is discarded.

## Timing
- Press latency: a key pin transition held stable from cycle t gives `key_deb` change at t+2+`DEBOUNCE_CYCLES` and `clk_en`=1 for exactly one cycle at t+3+`DEBOUNCE_CYCLES`.
- Release latency: `key_deb` returns to 1 `DEBOUNCE_CYCLES`+2 cycles after the pin release.
- Mode-change latency: a switch change reaches the FSM 2 cycles after the pin; the next state register (and `clk_en`) updates 1 cycle later.
- Bounce rejection: any bounce shorter than `DEBOUNCE_CYCLES` cycles produces no change in `key_deb`.
- Maximum step rate without auto-repeat: one PULSE per full press/release cycle.

## Configuration
- `STEP_AUTOREPEAT_EN` defined:
  - WAIT_REL runs a hold counter, cleared on PULSE entry.
  - The first PULSE after a press re-enters PULSE after `REPEAT_DELAY` cycles of continuous hold. Each later repeat occurs `REPEAT_PERIOD` cycles after the previous PULSE.
  - Every repeat increments `step_count`.
  - Release or reset stops repeating immediately.
- `STEP_AUTOREPEAT_EN` undefined: no hold counter is synthesized, and WAIT_REL leaves only on release.

## Test plan
Benches use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`.
- Reset with `sw_single=0`, then release reset -> `clk_en=0` during reset; `clk_en=1` continuously from the 3rd cycle after release; `step_count`=0.
- `sw_single=1`, clean press held 30 cycles at t -> exactly one `clk_en` pulse at t+7; `step_count`=1; no further pulses until release.
- Key bouncing with 3-cycle lows and highs for 40 cycles, then stable low -> exactly one pulse, 7 cycles after the last transition.
- 0xFFFF presses (fast-forced `step_count` preload allowed) -> `step_count` wraps to 0x0000 on the next pulse.
- Key held, `sw_single` 1->0 while held -> `clk_en` stays 0 until 6 cycles after the key is released, then 1 continuously.
- `STEP_AUTOREPEAT_EN` defined, key held 50 cycles -> pulses at t+7, t+27, t+35, t+43, t+51; none after release is debounced.
